instruction_fetch: RTL and testbench

- IF stage of the 5-stage pipeline, directly upstream of the IF/ID latch.
- Owns the program counter, next-PC selection (sequential / branch / jump), and addressing of the external instruction memory.
- Also owns the run-control FSM (idle, continuous run, single-step, halt-drain, halted). Its enableDebug output gates every pipeline latch.
- Presents programCounter_out / instruction_out for IF/ID to capture on the following negedge.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/instruction_fetch_if.sv | 39 +++
 rtl/instruction_fetch_run_control_fsm.sv | 89 ++++++++
 rtl/instruction_fetch.sv | 88 ++++++++
 tb/tb_instruction_fetch.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and constants for the fetch stage
package pipeline_pkg;

    localparam int          PC_WIDTH     = 8;
    localparam int          COUNT_WIDTH  = 16;
    localparam int          DRAIN_CYCLES = 4;
    localparam logic [31:0] HALT_WORD    = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_EXEC = 3'd3,
        DRAIN     = 3'd4,
        HALTED    = 3'd5
    } run_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch stage control, memory and IF/ID signal bundle
interface instruction_fetch_if #(
    parameter int PC_WIDTH    = 8,
    parameter int COUNT_WIDTH = 16
);
    logic                   stall_IF;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   jump;
    logic [PC_WIDTH-1:0]    jump_target;
    logic [31:0]            instruction_mem;
    logic                   debug_mode;
    logic                   debug_start;
    logic                   debug_step;
    logic [PC_WIDTH-1:0]    pc_out;
    logic [PC_WIDTH-1:0]    programCounter_out;
    logic [31:0]            instruction_out;
    logic                   enableDebug;
    logic                   clear;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] fetch_count;

    // Pipeline / memory / debug side
    modport master (
        output stall_IF, branch_taken, branch_target, jump, jump_target,
               instruction_mem, debug_mode, debug_start, debug_step,
        input  pc_out, programCounter_out, instruction_out, enableDebug,
               clear, halted, fetch_count
    );

    // Fetch stage side
    modport slave (
        input  stall_IF, branch_taken, branch_target, jump, jump_target,
               instruction_mem, debug_mode, debug_start, debug_step,
        output pc_out, programCounter_out, instruction_out, enableDebug,
               clear, halted, fetch_count
    );

endinterface

// File: rtl/instruction_fetch_run_control_fsm.sv
// rtl/instruction_fetch_run_control_fsm.sv - run/step/halt sequencing and pipeline enable
module run_control_fsm
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = pipeline_pkg::DRAIN_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       debug_mode_i,
    input  logic       debug_start_i,
    input  logic       debug_step_i,
    input  logic       halt_accept_i,
    output run_state_e state_o,
    output logic       enable_o,
    output logic       halted_o
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enable_q, enable_d;
    logic             halted_q, halted_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (debug_start_i) begin
                    state_d = debug_mode_i ? STEP_WAIT : RUN;
                end
            end
            RUN: begin
                if (halt_accept_i) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            STEP_WAIT: begin
                if (debug_step_i) begin
                    state_d = STEP_EXEC;
                end
            end
            STEP_EXEC: begin
                if (halt_accept_i) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    state_d = STEP_WAIT;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Enable and halted come straight from flops so downstream latches see clean levels.
    always_comb begin
        enable_d = (state_d == RUN) || (state_d == STEP_EXEC) || (state_d == DRAIN);
        halted_d = (state_d == HALTED);
    end

    assign state_o  = state_q;
    assign enable_o = enable_q;
    assign halted_o = halted_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: program counter, next-PC selection, fetch count
module instruction_fetch
    import pipeline_pkg::*;
#(
    parameter int          PC_WIDTH     = pipeline_pkg::PC_WIDTH,
    parameter logic [31:0] HALT_WORD    = pipeline_pkg::HALT_WORD,
    parameter int          DRAIN_CYCLES = pipeline_pkg::DRAIN_CYCLES,
    parameter int          COUNT_WIDTH  = pipeline_pkg::COUNT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    instruction_fetch_if.slave bus
);

    run_state_e             state;
    logic                   enable;
    logic                   halted;
    logic                   fetch_active;
    logic                   halt_accept;
    logic                   count_inc;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    run_control_fsm #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_run_control (
        .clk_i         (clk),
        .rst_ni        (reset),
        .debug_mode_i  (bus.debug_mode),
        .debug_start_i (bus.debug_start),
        .debug_step_i  (bus.debug_step),
        .halt_accept_i (halt_accept),
        .state_o       (state),
        .enable_o      (enable),
        .halted_o      (halted)
    );

    assign fetch_active = enable && ((state == RUN) || (state == STEP_EXEC));

    // Redirects beat stalls, stalls beat the halt decode.
    always_comb begin
        pc_d        = pc_q;
        count_inc   = 1'b0;
        halt_accept = 1'b0;
        if (fetch_active) begin
            if (bus.jump) begin
                pc_d = bus.jump_target;
            end else if (bus.branch_taken) begin
                pc_d = bus.branch_target;
            end else if (bus.stall_IF) begin
                pc_d = pc_q;
            end else if (bus.instruction_mem == HALT_WORD) begin
                halt_accept = 1'b1;
                count_inc   = 1'b1;
            end else begin
                pc_d      = pc_q + PC_WIDTH'(1);
                count_inc = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_inc && (count_q != '1)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign bus.pc_out             = pc_q;
    assign bus.programCounter_out = pc_q + PC_WIDTH'(1);
    assign bus.instruction_out    = ((state == DRAIN) || (state == HALTED)) ? NOP_WORD
                                                                            : bus.instruction_mem;
    assign bus.enableDebug        = enable;
    assign bus.clear              = (bus.branch_taken | bus.jump) & enable;
    assign bus.halted             = halted;
    assign bus.fetch_count        = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] mem [256];
    int          checks;
    int          errors;
    int          en_pulses;
    bit          count_en;

    instruction_fetch_if #(.PC_WIDTH(8), .COUNT_WIDTH(16)) bus ();

    instruction_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.instruction_mem = mem[bus.pc_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (count_en && bus.enableDebug) en_pulses++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        en_pulses = 0;
        count_en  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[7] = 32'hFFFF_FFFF;
        reset             = 1'b0;
        bus.stall_IF      = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 8'h00;
        bus.jump          = 1'b0;
        bus.jump_target   = 8'h00;
        bus.debug_mode    = 1'b0;
        bus.debug_start   = 1'b0;
        bus.debug_step    = 1'b0;

        #2;
        check("rst_en", 32'(bus.enableDebug), 32'd0);
        check("rst_clear", 32'(bus.clear), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_pc", 32'(bus.pc_out), 32'd0);
        check("rst_pcp1", 32'(bus.programCounter_out), 32'd1);
        check("rst_instr", bus.instruction_out, 32'h1000_0000);
        check("rst_count", 32'(bus.fetch_count), 32'd0);

        @(posedge clk); #1;
        reset = 1'b1;

        // continuous run
        bus.debug_start = 1'b1;
        tick();
        bus.debug_start = 1'b0;
        check("run_en", 32'(bus.enableDebug), 32'd1);
        check("run_pc0", 32'(bus.pc_out), 32'd0);
        tick();
        check("run_pc1", 32'(bus.pc_out), 32'd1);
        tick();
        check("run_pc2", 32'(bus.pc_out), 32'd2);
        tick();
        check("run_pc3", 32'(bus.pc_out), 32'd3);
        check("run_pcp1", 32'(bus.programCounter_out), 32'd4);
        check("run_instr", bus.instruction_out, 32'h1000_0003);
        check("run_count3", 32'(bus.fetch_count), 32'd3);
        tick();
        tick();
        check("run_pc5", 32'(bus.pc_out), 32'd5);

        // stall, then branch during stall
        bus.stall_IF = 1'b1;
        check("stall_clear", 32'(bus.clear), 32'd0);
        tick();
        check("stall_pc_a", 32'(bus.pc_out), 32'd5);
        tick();
        check("stall_pc_b", 32'(bus.pc_out), 32'd5);
        check("stall_count", 32'(bus.fetch_count), 32'd5);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h40;
        #1;
        check("br_clear", 32'(bus.clear), 32'd1);
        tick();
        check("br_pc", 32'(bus.pc_out), 32'h40);
        check("br_count", 32'(bus.fetch_count), 32'd5);
        bus.stall_IF = 1'b0;

        // jump and branch together
        bus.jump          = 1'b1;
        bus.jump_target   = 8'h10;
        bus.branch_target = 8'h20;
        tick();
        check("jmp_pri_pc", 32'(bus.pc_out), 32'h10);
        bus.branch_taken = 1'b0;

        // wrap at 255
        bus.jump_target = 8'hFF;
        tick();
        bus.jump = 1'b0;
        check("wrap_pc255", 32'(bus.pc_out), 32'hFF);
        check("wrap_pcp1", 32'(bus.programCounter_out), 32'd0);
        tick();
        check("wrap_pc0", 32'(bus.pc_out), 32'd0);
        check("wrap_count", 32'(bus.fetch_count), 32'd6);

        // halt at PC 7
        bus.jump        = 1'b1;
        bus.jump_target = 8'h07;
        tick();
        bus.jump = 1'b0;
        check("halt_pre_instr", bus.instruction_out, 32'hFFFF_FFFF);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("drain_en", 32'(bus.enableDebug), 32'd1);
            check("drain_instr", bus.instruction_out, 32'd0);
            check("drain_halted", 32'(bus.halted), 32'd0);
            check("drain_pc", 32'(bus.pc_out), 32'd7);
            tick();
        end
        check("halt_en", 32'(bus.enableDebug), 32'd0);
        check("halt_flag", 32'(bus.halted), 32'd1);
        check("halt_count", 32'(bus.fetch_count), 32'd7);
        bus.debug_step  = 1'b1;
        bus.debug_start = 1'b1;
        tick();
        bus.debug_step  = 1'b0;
        bus.debug_start = 1'b0;
        tick();
        tick();
        check("halt_stuck", 32'(bus.halted), 32'd1);
        check("halt_stuck_en", 32'(bus.enableDebug), 32'd0);
        check("halt_stuck_pc", 32'(bus.pc_out), 32'd7);

        // single step
        do_reset();
        bus.debug_mode  = 1'b1;
        bus.debug_start = 1'b1;
        tick();
        bus.debug_start = 1'b0;
        bus.debug_mode  = 1'b0;
        count_en = 1;
        for (int k = 1; k <= 3; k++) begin
            repeat (5) tick();
            check("step_wait_en", 32'(bus.enableDebug), 32'd0);
            check("step_wait_pc", 32'(bus.pc_out), 32'(k - 1));
            bus.debug_step = 1'b1;
            tick();
            bus.debug_step = 1'b0;
            check("step_exec_en", 32'(bus.enableDebug), 32'd1);
            check("step_exec_pc", 32'(bus.pc_out), 32'(k - 1));
            tick();
            check("step_after_pc", 32'(bus.pc_out), 32'(k));
            check("step_after_en", 32'(bus.enableDebug), 32'd0);
        end
        repeat (3) tick();
        count_en = 0;
        check("step_pulses", 32'(en_pulses), 32'd3);
        check("step_count", 32'(bus.fetch_count), 32'd3);

        // asynchronous reset in the middle of drain
        mem[1] = 32'hFFFF_FFFF;
        do_reset();
        bus.debug_start = 1'b1;
        tick();
        bus.debug_start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_drain_instr", bus.instruction_out, 32'd0);
        #3;
        reset = 1'b0;
        #1;
        check("async_en", 32'(bus.enableDebug), 32'd0);
        check("async_pc", 32'(bus.pc_out), 32'd0);
        check("async_pcp1", 32'(bus.programCounter_out), 32'd1);
        check("async_halted", 32'(bus.halted), 32'd0);
        check("async_count", 32'(bus.fetch_count), 32'd0);
        check("async_instr", bus.instruction_out, 32'h1000_0000);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("idle_en", 32'(bus.enableDebug), 32'd0);
        check("idle_pc", 32'(bus.pc_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
